spram_rr_scheduler: RTL

//  Shares one single-port RAM (spram: 1 port, registered read, 1-cycle latency) between NUM_REQ requesters.

---
 rtl/spram_rr_scheduler_pkg.sv | 20 ++
 rtl/spram_rr_scheduler_if.sv | 28 ++
 rtl/spram_rr_scheduler_arbiter.sv | 71 +++++++
 rtl/spram_rr_scheduler.sv | 70 +++++++
 4 files changed

// File: rtl/spram_rr_scheduler_pkg.sv
// Shared types and helpers for the single-port RAM round-robin scheduler.
// Optional grant locking is enabled with the SPRAM_SCHED_LOCK_EN macro.
package spram_sched_pkg;

    localparam int SCHED_DATA_W = 8;
    localparam int SCHED_ADDR_W = 4;
    localparam int unsigned PTR_RESET = 0;

    typedef struct packed {
        logic                    we;
        logic [SCHED_ADDR_W-1:0] addr;
        logic [SCHED_DATA_W-1:0] wdata;
    } sched_cmd_t;

    // Explicit wrap so that a non-power-of-2 requester count never reaches an unused index.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned numReq);
        return (ptr + 1 >= numReq) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/spram_rr_scheduler_if.sv
// Requester-side command/response bundle of the spram scheduler.
// req_lock only exists when SPRAM_SCHED_LOCK_EN is defined.
interface spram_rr_scheduler_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0]                 req_ready;
    logic [NUM_REQ-1:0]                 req_we;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]                 rsp_valid;
    logic [DATA_WIDTH-1:0]              rsp_data;
`ifdef SPRAM_SCHED_LOCK_EN
    logic [NUM_REQ-1:0]                 req_lock;

    modport master (output req_valid, req_we, req_addr, req_wdata, req_lock,
                    input  req_ready, rsp_valid, rsp_data);
    modport slave  (input  req_valid, req_we, req_addr, req_wdata, req_lock,
                    output req_ready, rsp_valid, rsp_data);
`else
    modport master (output req_valid, req_we, req_addr, req_wdata,
                    input  req_ready, rsp_valid, rsp_data);
    modport slave  (input  req_valid, req_we, req_addr, req_wdata,
                    output req_ready, rsp_valid, rsp_data);
`endif
endinterface

// File: rtl/spram_rr_scheduler_arbiter.sv
// Reusable round-robin arbiter: request vector in, one-hot grant and winner index out.
// With SPRAM_SCHED_LOCK_EN a winner asserting lock keeps priority while it stays valid.
module rr_arbiter
    import spram_sched_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NUM_REQ-1:0]  req_i,
    input  logic                advance_i,
`ifdef SPRAM_SCHED_LOCK_EN
    input  logic [NUM_REQ-1:0]  lock_i,
`endif
    output logic [NUM_REQ-1:0]  grant_o,
    output logic [ID_WIDTH-1:0] winner_o
);

    logic [ID_WIDTH-1:0] ptr_q, ptr_d;
    logic                found;
    int unsigned         idx;
`ifdef SPRAM_SCHED_LOCK_EN
    logic                locked_q, locked_d;
    logic [ID_WIDTH-1:0] holder_q, holder_d;
`endif

    always_comb begin
        grant_o  = '0;
        winner_o = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = 32'(ptr_q) + 32'(k);
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_i[ID_WIDTH'(idx)]) begin
                found    = 1'b1;
                winner_o = ID_WIDTH'(idx);
            end
        end
`ifdef SPRAM_SCHED_LOCK_EN
        // A held lock overrides the round-robin search for as long as the holder stays valid.
        if (locked_q && req_i[holder_q]) begin
            found    = 1'b1;
            winner_o = holder_q;
        end
        locked_d = advance_i && found && lock_i[winner_o];
        holder_d = winner_o;
`endif
        if (found) grant_o[winner_o] = 1'b1;
        ptr_d = ptr_q;
        if (advance_i && found) ptr_d = ID_WIDTH'(ptr_inc(32'(winner_o), NUM_REQ));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= ID_WIDTH'(PTR_RESET);
`ifdef SPRAM_SCHED_LOCK_EN
            locked_q <= 1'b0;
            holder_q <= '0;
`endif
        end else begin
            ptr_q <= ptr_d;
`ifdef SPRAM_SCHED_LOCK_EN
            locked_q <= locked_d;
            holder_q <= holder_d;
`endif
        end
    end

endmodule

// File: rtl/spram_rr_scheduler.sv
// Shares one single-port RAM (1-cycle registered read) between NUM_REQ requesters, round-robin.
// Define SPRAM_SCHED_LOCK_EN to add per-requester grant locking via req_lock.
module spram_rr_scheduler
    import spram_sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = SCHED_DATA_W,
    parameter int ADDR_WIDTH = SCHED_ADDR_W,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    spram_rr_scheduler_if.slave   bus,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_din_o,
    input  logic [DATA_WIDTH-1:0] mem_dout_i
);

    logic [NUM_REQ-1:0]  reqValid;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_WIDTH-1:0] winner;
    logic                cmdTaken;
    sched_cmd_t          cmd;
    logic [NUM_REQ-1:0]  rspValid_q, rspValid_d;

    // Masking valid during reset keeps ready low and stops any command reaching the RAM.
    assign reqValid = bus.req_valid & {NUM_REQ{~rst_i}};
    assign cmdTaken = |grant;

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (reqValid),
        .advance_i (cmdTaken),
`ifdef SPRAM_SCHED_LOCK_EN
        .lock_i    (bus.req_lock),
`endif
        .grant_o   (grant),
        .winner_o  (winner)
    );

    always_comb begin
        cmd = '0;
        if (cmdTaken) begin
            cmd.we    = bus.req_we[winner];
            cmd.addr  = bus.req_addr[winner];
            cmd.wdata = bus.req_wdata[winner];
        end
        rspValid_d = cmd.we ? '0 : grant;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) rspValid_q <= '0;
        else       rspValid_q <= rspValid_d;
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = rspValid_q;
    assign bus.rsp_data  = mem_dout_i;
    assign mem_en_o      = cmdTaken;
    assign mem_we_o      = cmd.we;
    assign mem_addr_o    = cmd.addr;
    assign mem_din_o     = cmd.wdata;

endmodule
